up_down_counter_mod: RTL and testbench

- Parametrised successor to the team's 4-bit loadable up/down counter.
- Generalised in width, with a programmable modulus (terminal value) and a selectable wrap or saturate mode.
- Adds a count enable, terminal-count flags and a registered wrap/limit event pulse.
- Used as a generic event/timer counter. A decade or BCD digit is WIDTH=4, MAX_VAL=9. Instances can be cascaded via en/tc.

---
 rtl/up_down_counter_mod_pkg.sv | 11 +
 rtl/up_down_counter_mod.sv | 62 ++++++
 tb/tb_up_down_counter_mod.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/up_down_counter_mod_pkg.sv
// Shared constants for the parametrised up/down counter.
// Mode and direction encodings used by instances and wrappers.
package up_down_counter_mod_pkg;

    localparam bit   CNT_WRAP = 1'b0;
    localparam bit   CNT_SAT  = 1'b1;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/up_down_counter_mod.sv
// Loadable up/down counter with programmable modulus, wrap or saturate
// mode, cascade-friendly terminal-count flag and a registered limit pulse.
module up_down_counter_mod
    import up_down_counter_mod_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             ctrl,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             limit
);

    logic             at_top;
    logic             at_bot;
    logic [WIDTH-1:0] load_val;

    assign at_top   = (count == MAX_VAL);
    assign at_bot   = (count == '0);
    assign load_val = (data > MAX_VAL) ? MAX_VAL : data;

    // Flag is valid ahead of the wrapping edge so it can enable the next stage.
    assign tc = en && ((ctrl == DIR_UP) ? at_top : at_bot);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            limit <= 1'b0;
        end else if (load) begin
            count <= load_val;
            limit <= 1'b0;
        end else if (en) begin
            if (ctrl == DIR_UP) begin
                if (at_top) begin
                    count <= (SATURATE == CNT_SAT) ? MAX_VAL : '0;
                    limit <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                    limit <= 1'b0;
                end
            end else begin
                if (at_bot) begin
                    count <= (SATURATE == CNT_SAT) ? '0 : MAX_VAL;
                    limit <= 1'b1;
                end else begin
                    count <= count - 1'b1;
                    limit <= 1'b0;
                end
            end
        end else begin
            limit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Bench for up_down_counter_mod: vector table, directed corner
// sequences, a BCD cascade and randomized runs against a reference model.
module tb_up_down_counter_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // a: WIDTH=4 MAX=9 wrap; b: WIDTH=4 MAX=9 saturate; c: WIDTH=8 wrap
    logic       a_rst, a_load, a_en, a_ctrl, a_tc, a_limit;
    logic [3:0] a_data, a_count;
    logic       b_rst, b_load, b_en, b_ctrl, b_tc, b_limit;
    logic [3:0] b_data, b_count;
    logic       c_rst, c_load, c_en, c_ctrl, c_tc, c_limit;
    logic [7:0] c_data, c_count;
    logic       s_rst, s0_en, s0_tc, s0_limit, s1_tc, s1_limit;
    logic [3:0] s0_count, s1_count;

    up_down_counter_mod #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .load(a_load), .ctrl(a_ctrl),
        .data(a_data), .count(a_count), .tc(a_tc), .limit(a_limit));

    up_down_counter_mod #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .load(b_load), .ctrl(b_ctrl),
        .data(b_data), .count(b_count), .tc(b_tc), .limit(b_limit));

    up_down_counter_mod #(.WIDTH(8)) u_c (
        .clk(clk), .rst(c_rst), .en(c_en), .load(c_load), .ctrl(c_ctrl),
        .data(c_data), .count(c_count), .tc(c_tc), .limit(c_limit));

    up_down_counter_mod #(.WIDTH(4), .MAX_VAL(4'd9)) u_s0 (
        .clk(clk), .rst(s_rst), .en(s0_en), .load(1'b0), .ctrl(1'b1),
        .data(4'd0), .count(s0_count), .tc(s0_tc), .limit(s0_limit));

    up_down_counter_mod #(.WIDTH(4), .MAX_VAL(4'd9)) u_s1 (
        .clk(clk), .rst(s_rst), .en(s0_tc), .load(1'b0), .ctrl(1'b1),
        .data(4'd0), .count(s1_count), .tc(s1_tc), .limit(s1_limit));

    typedef struct {
        bit       rst;
        bit       load;
        bit       en;
        bit       ctrl;
        int       data;
        int       cnt;
        bit       lim;
        bit       tc;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    function automatic vec_t mk(bit r, bit ld, bit e, bit c, int d,
                                int cnt, bit lim, bit tc);
        vec_t v;
        v.rst = r; v.load = ld; v.en = e; v.ctrl = c; v.data = d;
        v.cnt = cnt; v.lim = lim; v.tc = tc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: value arithmetic on plain integers over the range 0..mx.
    function automatic void ref_step(input int cnt, input bit r, input bit ld,
                                     input bit e, input bit up, input int d,
                                     input int mx, input bit sat,
                                     output int nc, output bit nl);
        int n;
        nc = cnt;
        nl = 1'b0;
        if (r) begin
            nc = 0;
        end else if (ld) begin
            nc = (d > mx) ? mx : d;
        end else if (e) begin
            n = up ? cnt + 1 : cnt - 1;
            if (n > mx || n < 0) begin
                nl = 1'b1;
                nc = sat ? cnt : (up ? 0 : mx);
            end else begin
                nc = n;
            end
        end
    endfunction

    function automatic bit ref_tc(input int cnt, input bit e, input bit up,
                                  input int mx);
        return e && (up ? (cnt == mx) : (cnt == 0));
    endfunction

    task automatic idle_all();
        a_rst = 0; a_load = 0; a_en = 0; a_ctrl = 1; a_data = 0;
        b_rst = 0; b_load = 0; b_en = 0; b_ctrl = 1; b_data = 0;
        c_rst = 0; c_load = 0; c_en = 0; c_ctrl = 1; c_data = 0;
        s_rst = 0; s0_en = 0;
    endtask

    initial begin
        int ma, mb, mc, nc;
        bit nl;
        bit r, ld, e, up;
        int d;

        // up 0..9 wrap, back to 2
        vecs.push_back(mk(0,0,1,1,0, 1,0,0));
        vecs.push_back(mk(0,0,1,1,0, 2,0,0));
        vecs.push_back(mk(0,0,1,1,0, 3,0,0));
        vecs.push_back(mk(0,0,1,1,0, 4,0,0));
        vecs.push_back(mk(0,0,1,1,0, 5,0,0));
        vecs.push_back(mk(0,0,1,1,0, 6,0,0));
        vecs.push_back(mk(0,0,1,1,0, 7,0,0));
        vecs.push_back(mk(0,0,1,1,0, 8,0,0));
        vecs.push_back(mk(0,0,1,1,0, 9,0,0));
        vecs.push_back(mk(0,0,1,1,0, 0,1,1));
        vecs.push_back(mk(0,0,1,1,0, 1,0,0));
        vecs.push_back(mk(0,0,1,1,0, 2,0,0));
        // load 2 then count down through 0 -> 9
        vecs.push_back(mk(0,1,0,1,2, 2,0,0));
        vecs.push_back(mk(0,0,1,0,0, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 9,1,1));
        vecs.push_back(mk(0,0,1,0,0, 8,0,0));
        // load wins over en and clamps 14 to 9
        vecs.push_back(mk(0,1,1,1,14, 9,0,0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0,0,0,1,0, 9,0,0));
        // wrap due, then reset clears the pending event
        vecs.push_back(mk(0,0,1,1,0, 0,1,1));
        vecs.push_back(mk(1,1,1,0,5, 0,0,1));
        vecs.push_back(mk(0,0,0,0,0, 0,0,0));

        idle_all();
        a_rst = 1; b_rst = 1; c_rst = 1; s_rst = 1;
        a_load = 1; a_en = 1; a_data = 4'd5;
        tick();
        chk("rst_a_count", a_count, 0);
        chk("rst_a_limit", a_limit, 0);
        chk("rst_b_count", b_count, 0);
        chk("rst_b_limit", b_limit, 0);
        chk("rst_c_count", c_count, 0);
        chk("rst_c_limit", c_limit, 0);
        chk("rst_s0_count", s0_count, 0);
        chk("rst_s1_count", s1_count, 0);
        idle_all();

        foreach (vecs[i]) begin
            a_rst = vecs[i].rst; a_load = vecs[i].load;
            a_en = vecs[i].en; a_ctrl = vecs[i].ctrl;
            a_data = 4'(vecs[i].data);
            #1;
            chk($sformatf("vec%0d_tc", i), a_tc, vecs[i].tc);
            tick();
            chk($sformatf("vec%0d_count", i), a_count, vecs[i].cnt);
            chk($sformatf("vec%0d_limit", i), a_limit, vecs[i].lim);
        end
        idle_all();

        // saturate: 8 -> 9 -> 9 -> 9, then step down to 8
        b_load = 1; b_data = 4'd8;
        tick();
        chk("sat_load", b_count, 8);
        b_load = 0; b_en = 1; b_ctrl = 1;
        #1;
        chk("sat_tc0", b_tc, 0);
        tick();
        chk("sat_e1_count", b_count, 9);
        chk("sat_e1_limit", b_limit, 0);
        chk("sat_tc1", b_tc, 1);
        tick();
        chk("sat_e2_count", b_count, 9);
        chk("sat_e2_limit", b_limit, 1);
        tick();
        chk("sat_e3_count", b_count, 9);
        chk("sat_e3_limit", b_limit, 1);
        b_ctrl = 0;
        tick();
        chk("sat_dn_count", b_count, 8);
        chk("sat_dn_limit", b_limit, 0);
        b_en = 0; b_ctrl = 0; b_load = 1; b_data = 4'd0;
        tick();
        b_load = 0; b_en = 1;
        #1;
        chk("sat_bot_tc", b_tc, 1);
        tick();
        chk("sat_bot_count", b_count, 0);
        chk("sat_bot_limit", b_limit, 1);
        idle_all();

        // 8-bit natural overflow and immediate direction change
        c_load = 1; c_data = 8'd254;
        tick();
        chk("w8_load", c_count, 254);
        c_load = 0; c_en = 1; c_ctrl = 1;
        tick();
        chk("w8_up1_count", c_count, 255);
        chk("w8_up1_limit", c_limit, 0);
        tick();
        chk("w8_up2_count", c_count, 0);
        chk("w8_up2_limit", c_limit, 1);
        c_ctrl = 0;
        tick();
        chk("w8_dn_count", c_count, 255);
        chk("w8_dn_limit", c_limit, 1);
        c_rst = 1; c_load = 1; c_data = 8'd7;
        tick();
        chk("w8_rst_count", c_count, 0);
        chk("w8_rst_limit", c_limit, 0);
        idle_all();

        // BCD cascade: stage1 steps on stage0's terminal count
        s_rst = 1;
        tick();
        s_rst = 0; s0_en = 1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            chk($sformatf("casc_%0d", i),
                32'(s1_count) * 10 + 32'(s0_count), i);
        end
        chk("casc_s1", s1_count, 2);
        chk("casc_s0", s0_count, 5);
        idle_all();

        // randomized runs on all three standalone instances
        a_rst = 1; b_rst = 1; c_rst = 1;
        tick();
        idle_all();
        ma = 0; mb = 0; mc = 0;
        for (int i = 0; i < 400; i++) begin
            a_rst = ($urandom_range(0, 49) == 0);
            a_load = ($urandom_range(0, 9) == 0);
            a_en = ($urandom_range(0, 3) != 0);
            a_ctrl = 1'($urandom_range(0, 1));
            a_data = 4'($urandom_range(0, 15));
            b_rst = ($urandom_range(0, 49) == 0);
            b_load = ($urandom_range(0, 9) == 0);
            b_en = ($urandom_range(0, 3) != 0);
            b_ctrl = 1'($urandom_range(0, 1));
            b_data = 4'($urandom_range(0, 15));
            c_rst = ($urandom_range(0, 49) == 0);
            c_load = ($urandom_range(0, 9) == 0);
            c_en = ($urandom_range(0, 3) != 0);
            c_ctrl = 1'($urandom_range(0, 1));
            c_data = 8'($urandom_range(0, 255));
            #1;
            chk("rnd_a_tc", a_tc, ref_tc(ma, a_en, a_ctrl, 9));
            chk("rnd_b_tc", b_tc, ref_tc(mb, b_en, b_ctrl, 9));
            chk("rnd_c_tc", c_tc, ref_tc(mc, c_en, c_ctrl, 255));
            tick();
            r = a_rst; ld = a_load; e = a_en; up = a_ctrl; d = int'(a_data);
            ref_step(ma, r, ld, e, up, d, 9, 1'b0, nc, nl);
            ma = nc;
            chk("rnd_a_count", a_count, ma);
            chk("rnd_a_limit", a_limit, nl);
            r = b_rst; ld = b_load; e = b_en; up = b_ctrl; d = int'(b_data);
            ref_step(mb, r, ld, e, up, d, 9, 1'b1, nc, nl);
            mb = nc;
            chk("rnd_b_count", b_count, mb);
            chk("rnd_b_limit", b_limit, nl);
            r = c_rst; ld = c_load; e = c_en; up = c_ctrl; d = int'(c_data);
            ref_step(mc, r, ld, e, up, d, 255, 1'b0, nc, nl);
            mc = nc;
            chk("rnd_c_count", c_count, mc);
            chk("rnd_c_limit", c_limit, nl);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
